// File: rtl/calc1_sched.sv
// Request scheduler for the calc1 datapath: per-port command FSMs, independent
// round-robin arbiters for the adder and shifter, and fixed-latency retire pipelines.
module calc1_sched #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:15] hold_prio_req,
  output logic [0:3]  prio_alu1_in_cmd,
  output logic [0:1]  prio_alu1_in_req_id,
  output logic [0:3]  prio_alu2_in_cmd,
  output logic [0:1]  prio_alu2_in_req_id,
  output logic        prio_alu1_out_vld,
  output logic [0:1]  prio_alu1_out_req_id,
  output logic        prio_alu2_out_vld,
  output logic [0:1]  prio_alu2_out_req_id,
  output logic        inv_vld,
  output logic [0:1]  inv_req_id,
  output logic [0:3]  drop_err
);

  typedef enum logic [1:0] {StIdle, StPend, StBusy} st_e;

  st_e        r_st [4];
  st_e        w_st_d [4];
  logic [3:0] r_cmd [4];
  logic [3:0] w_cmd_d [4];
  logic [3:0] w_req [4];
  logic [1:0] r_rr1, r_rr2;
  logic [3:0] w_el1, w_el2, w_elinv, w_ret;
  logic [0:3] w_drop, r_drop;
  logic [2:0] w_pick1, w_pick2, w_pickinv;

  logic [3:0] r_a1_cmd, r_a2_cmd;
  logic [1:0] r_a1_id, r_a2_id;
  logic       r_inv_vld;
  logic [1:0] r_inv_id;
  logic [ALU_LAT-1:0]       r_p1_vld, r_p2_vld;
  logic [ALU_LAT-1:0][1:0]  r_p1_id, r_p2_id;

  logic       w_o1_vld, w_o2_vld;
  logic [1:0] w_o1_id, w_o2_id;

  assign w_o1_vld = r_p1_vld[ALU_LAT-1];
  assign w_o2_vld = r_p2_vld[ALU_LAT-1];
  assign w_o1_id  = r_p1_id[ALU_LAT-1];
  assign w_o2_id  = r_p2_id[ALU_LAT-1];

  // Returns {found, port}; scanning downward leaves the port nearest ptr as winner.
  function automatic logic [2:0] rr_pick(input logic [3:0] el, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (el[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_req[n]   = hold_prio_req[4*n +: 4];
      w_el1[n]   = (r_st[n] == StPend) && (r_cmd[n] == 4'd1 || r_cmd[n] == 4'd2);
      w_el2[n]   = (r_st[n] == StPend) && (r_cmd[n] == 4'd5 || r_cmd[n] == 4'd6);
      w_elinv[n] = (r_st[n] == StPend) && !(w_el1[n] || w_el2[n]);
      w_ret[n]   = (w_o1_vld && w_o1_id == 2'(n)) || (w_o2_vld && w_o2_id == 2'(n));
    end
  end

  assign w_pick1   = rr_pick(w_el1, r_rr1);
  assign w_pick2   = rr_pick(w_el2, r_rr2);
  assign w_pickinv = rr_pick(w_elinv, 2'd0);

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_st_d[n]  = r_st[n];
      w_cmd_d[n] = r_cmd[n];
      w_drop[n]  = 1'b0;
      unique case (r_st[n])
        StIdle: begin
          if (w_req[n] != 4'd0) begin
            w_cmd_d[n] = w_req[n];
            w_st_d[n]  = StPend;
          end
        end
        StPend: begin
          w_drop[n] = (w_req[n] != 4'd0);
          if ((w_pick1[2] && w_pick1[1:0] == 2'(n)) || (w_pick2[2] && w_pick2[1:0] == 2'(n))) begin
            w_st_d[n] = StBusy;
          end else if (w_pickinv[2] && w_pickinv[1:0] == 2'(n)) begin
            w_st_d[n] = StIdle;
          end
        end
        StBusy: begin
          if (w_ret[n]) begin
            if (w_req[n] != 4'd0) begin
              w_cmd_d[n] = w_req[n];
              w_st_d[n]  = StPend;
            end else begin
              w_st_d[n] = StIdle;
            end
          end else begin
            w_drop[n] = (w_req[n] != 4'd0);
          end
        end
        default: w_st_d[n] = StIdle;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        r_st[n]  <= StIdle;
        r_cmd[n] <= 4'd0;
      end
      r_rr1     <= 2'd0;
      r_rr2     <= 2'd0;
      r_drop    <= '0;
      r_a1_cmd  <= 4'd0;
      r_a1_id   <= 2'd0;
      r_a2_cmd  <= 4'd0;
      r_a2_id   <= 2'd0;
      r_inv_vld <= 1'b0;
      r_inv_id  <= 2'd0;
      r_p1_vld  <= '0;
      r_p1_id   <= '0;
      r_p2_vld  <= '0;
      r_p2_id   <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_st[n]  <= w_st_d[n];
        r_cmd[n] <= w_cmd_d[n];
      end
      r_drop    <= w_drop;
      r_a1_cmd  <= w_pick1[2] ? r_cmd[w_pick1[1:0]] : 4'd0;
      r_a1_id   <= w_pick1[1:0];
      r_rr1     <= w_pick1[2] ? w_pick1[1:0] + 2'd1 : r_rr1;
      r_a2_cmd  <= w_pick2[2] ? r_cmd[w_pick2[1:0]] : 4'd0;
      r_a2_id   <= w_pick2[1:0];
      r_rr2     <= w_pick2[2] ? w_pick2[1:0] + 2'd1 : r_rr2;
      r_inv_vld <= w_pickinv[2];
      r_inv_id  <= w_pickinv[1:0];
      // Pipelines are fed from the registered issue, so out_vld lands ALU_LAT after in_cmd.
      r_p1_vld[0] <= (r_a1_cmd != 4'd0);
      r_p1_id[0]  <= r_a1_id;
      r_p2_vld[0] <= (r_a2_cmd != 4'd0);
      r_p2_id[0]  <= r_a2_id;
      for (int k = 1; k < int'(ALU_LAT); k++) begin
        r_p1_vld[k] <= r_p1_vld[k-1];
        r_p1_id[k]  <= r_p1_id[k-1];
        r_p2_vld[k] <= r_p2_vld[k-1];
        r_p2_id[k]  <= r_p2_id[k-1];
      end
    end
  end

  assign prio_alu1_in_cmd     = r_a1_cmd;
  assign prio_alu1_in_req_id  = r_a1_id;
  assign prio_alu2_in_cmd     = r_a2_cmd;
  assign prio_alu2_in_req_id  = r_a2_id;
  assign prio_alu1_out_vld    = w_o1_vld;
  assign prio_alu1_out_req_id = w_o1_id;
  assign prio_alu2_out_vld    = w_o2_vld;
  assign prio_alu2_out_req_id = w_o2_id;
  assign inv_vld              = r_inv_vld;
  assign inv_req_id           = r_inv_id;
  assign drop_err             = r_drop;

endmodule

// File: tb/tb_calc1_sched.sv
// Directed bench for calc1_sched: per-cycle vector table plus a reset-mid-flight sequence.
module tb_calc1_sched;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:15] hold_prio_req = '0;
  logic [0:3]  prio_alu1_in_cmd, prio_alu2_in_cmd, drop_err;
  logic [0:1]  prio_alu1_in_req_id, prio_alu2_in_req_id;
  logic        prio_alu1_out_vld, prio_alu2_out_vld, inv_vld;
  logic [0:1]  prio_alu1_out_req_id, prio_alu2_out_req_id, inv_req_id;

  calc1_sched #(.ALU_LAT(2)) dut (
    .c_clk               (c_clk),
    .reset               (reset),
    .hold_prio_req       (hold_prio_req),
    .prio_alu1_in_cmd    (prio_alu1_in_cmd),
    .prio_alu1_in_req_id (prio_alu1_in_req_id),
    .prio_alu2_in_cmd    (prio_alu2_in_cmd),
    .prio_alu2_in_req_id (prio_alu2_in_req_id),
    .prio_alu1_out_vld   (prio_alu1_out_vld),
    .prio_alu1_out_req_id(prio_alu1_out_req_id),
    .prio_alu2_out_vld   (prio_alu2_out_vld),
    .prio_alu2_out_req_id(prio_alu2_out_req_id),
    .inv_vld             (inv_vld),
    .inv_req_id          (inv_req_id),
    .drop_err            (drop_err)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       nm;
    logic        rst;
    logic [15:0] req;
    logic [24:0] exp;
    logic        chk;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [24:0] Z = 25'd0;

  // Output word layout: a1c a1i a2c a2i o1v o1i o2v o2i iv ii drop
  function automatic logic [24:0] a1(input logic [3:0] c, input logic [1:0] i);
    return {c, i, 19'd0};
  endfunction
  function automatic logic [24:0] a2(input logic [3:0] c, input logic [1:0] i);
    return {6'd0, c, i, 13'd0};
  endfunction
  function automatic logic [24:0] o1(input logic [1:0] i);
    return {12'd0, 1'b1, i, 10'd0};
  endfunction
  function automatic logic [24:0] o2(input logic [1:0] i);
    return {15'd0, 1'b1, i, 7'd0};
  endfunction
  function automatic logic [24:0] inv(input logic [1:0] i);
    return {18'd0, 1'b1, i, 4'd0};
  endfunction
  function automatic logic [24:0] dr(input logic [3:0] d);
    return {21'd0, d};
  endfunction

  function automatic logic [24:0] outs();
    return {prio_alu1_in_cmd, prio_alu1_in_req_id, prio_alu2_in_cmd, prio_alu2_in_req_id,
            prio_alu1_out_vld, prio_alu1_out_req_id, prio_alu2_out_vld, prio_alu2_out_req_id,
            inv_vld, inv_req_id, drop_err};
  endfunction

  task automatic row(input string nm, input logic rst, input logic [15:0] req,
                     input logic [24:0] exp, input logic chk);
    vec_t v;
    v.nm = nm; v.rst = rst; v.req = req; v.exp = exp; v.chk = chk;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [24:0] act, input logic [24:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge c_clk);
  endtask

  logic [24:0] acc;
  int          wait_n;
  logic        found;

  initial begin
    // Test 1: single add, then reissue to show the port is idle again
    row("t1.rst", 1, 16'h5555, Z, 0);
    row("t1.c0", 0, 16'h1000, Z, 1);
    row("t1.c1", 0, 16'h0000, Z, 1);
    row("t1.c2", 0, 16'h0000, a1(1, 0), 1);
    row("t1.c3", 0, 16'h0000, Z, 1);
    row("t1.c4", 0, 16'h0000, o1(0), 1);
    row("t1.c5", 0, 16'h2000, Z, 1);
    row("t1.c6", 0, 16'h0000, Z, 1);
    row("t1.c7", 0, 16'h0000, a1(2, 0), 1);
    row("t1.c8", 0, 16'h0000, Z, 1);
    row("t1.c9", 0, 16'h0000, o1(0), 1);
    // Test 2: adder contention and round-robin wrap
    row("t2.rst", 1, 16'h5555, Z, 0);
    row("t2.c0", 0, 16'h2222, Z, 1);
    row("t2.c1", 0, 16'h0000, Z, 1);
    row("t2.c2", 0, 16'h0000, a1(2, 0), 1);
    row("t2.c3", 0, 16'h0000, a1(2, 1), 1);
    row("t2.c4", 0, 16'h0000, a1(2, 2) | o1(0), 1);
    row("t2.c5", 0, 16'h0000, a1(2, 3) | o1(1), 1);
    row("t2.c6", 0, 16'h0000, o1(2), 1);
    row("t2.c7", 0, 16'h2020, o1(3), 1);
    row("t2.c8", 0, 16'h0000, Z, 1);
    row("t2.c9", 0, 16'h0000, a1(2, 0), 1);
    row("t2.c10", 0, 16'h0000, a1(2, 2), 1);
    row("t2.c11", 0, 16'h0000, o1(0), 1);
    row("t2.c12", 0, 16'h0000, o1(2), 1);
    row("t2.c13", 0, 16'h0000, Z, 1);
    // Test 3: both units in parallel
    row("t3.rst", 1, 16'h5555, Z, 0);
    row("t3.c0", 0, 16'h1500, Z, 1);
    row("t3.c1", 0, 16'h0000, Z, 1);
    row("t3.c2", 0, 16'h0000, a1(1, 0) | a2(5, 1), 1);
    row("t3.c3", 0, 16'h0000, Z, 1);
    row("t3.c4", 0, 16'h0000, o1(0) | o2(1), 1);
    row("t3.c5", 0, 16'h0000, Z, 1);
    // Test 4: invalid command, drop while pending, invalid priority
    row("t4.rst", 1, 16'h5555, Z, 0);
    row("t4.c0", 0, 16'h0040, Z, 1);
    row("t4.c1", 0, 16'h0010, Z, 1);
    row("t4.c2", 0, 16'h0000, inv(2) | dr(4'b0010), 1);
    row("t4.c3", 0, 16'h0F07, Z, 1);
    row("t4.c4", 0, 16'h0000, Z, 1);
    row("t4.c5", 0, 16'h0000, inv(1), 1);
    row("t4.c6", 0, 16'h0000, inv(3), 1);
    row("t4.c7", 0, 16'h0000, Z, 1);
    // Test 5: drop while busy, then capture in the retire cycle
    row("t5.rst", 1, 16'h5555, Z, 0);
    row("t5.c0", 0, 16'h0001, Z, 1);
    row("t5.c1", 0, 16'h0000, Z, 1);
    row("t5.c2", 0, 16'h0000, a1(1, 3), 1);
    row("t5.c3", 0, 16'h0005, Z, 1);
    row("t5.c4", 0, 16'h0006, o1(3) | dr(4'b0001), 1);
    row("t5.c5", 0, 16'h0000, Z, 1);
    row("t5.c6", 0, 16'h0000, a2(6, 3), 1);
    row("t5.c7", 0, 16'h0000, Z, 1);
    row("t5.c8", 0, 16'h0000, o2(3), 1);
    row("t5.c9", 0, 16'h0000, Z, 1);

    foreach (tbl[i]) begin
      cyc();
      if (tbl[i].chk) check(tbl[i].nm, outs(), tbl[i].exp);
      reset = tbl[i].rst;
      hold_prio_req = tbl[i].req;
    end

    // Test 6: reset mid-flight discards everything, then a fresh issue
    cyc(); reset = 1'b1; hold_prio_req = 16'h0000;
    cyc(); reset = 1'b0; hold_prio_req = 16'h2222;
    check("t6.c0", outs(), Z);
    cyc(); hold_prio_req = 16'h0000;
    cyc(); check("t6.c2", outs(), a1(2, 0));
    cyc(); check("t6.c3", outs(), a1(2, 1)); reset = 1'b1;
    cyc(); reset = 1'b0; check("t6.clr", outs(), Z);
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      acc |= outs();
    end
    check("t6.quiet", acc, Z);
    hold_prio_req = 16'h0100;
    cyc(); hold_prio_req = 16'h0000;
    wait_n = 1;
    found = (prio_alu1_in_cmd != 4'd0);
    while (!found && wait_n < 6) begin
      cyc();
      wait_n++;
      found = (prio_alu1_in_cmd != 4'd0);
    end
    check("t6.lat", 25'(wait_n), 25'd2);
    check("t6.issue", outs(), a1(1, 1));
    cyc();
    cyc(); check("t6.out", outs(), o1(1));
    cyc(); check("t6.end", outs(), Z);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
